l1_sdram_arbiter: RTL

Two-port arbiter that shares the single SDRAM controller bus between the L1 instruction cache and the L1 data cache. Each cache presents its SDRAM-side bus (addr/data/we/start, level-held start until done) to one port. The arbiter grants one transaction at a time, forwards it with registered signals, and routes the controller's response back to the granted cache only. It sits between the two L1 caches and the SDRAM controller.

---
 rtl/l1_sdram_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/l1_sdram_arbiter.sv
// Two-port arbiter sharing one SDRAM controller bus between the L1 I-cache and D-cache.
// Tie policy: ARB_ROUND_ROBIN_EN defined -> round robin, undefined -> data port always wins.
module l1_sdram_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_we,
  input  logic              i_start,
  output logic [DATA_W-1:0] i_q,
  output logic              i_done,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_data,
  input  logic              d_we,
  input  logic              d_start,
  output logic [DATA_W-1:0] d_q,
  output logic              d_done,
  output logic [ADDR_W-1:0] sdc_addr,
  output logic [DATA_W-1:0] sdc_data,
  output logic              sdc_we,
  output logic              sdc_start,
  input  logic [DATA_W-1:0] sdc_q,
  input  logic              sdc_done
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;
  localparam logic [1:0] GAP    = 2'd3;

  localparam logic LG_I = 1'b0;
  localparam logic LG_D = 1'b1;

  logic [1:0]        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] sdc_addr_q, sdc_addr_d;
  logic [DATA_W-1:0] sdc_data_q, sdc_data_d;
  logic              sdc_we_q, sdc_we_d;
  logic              sdc_start_q, sdc_start_d;
  logic [DATA_W-1:0] i_q_q, i_q_d;
  logic [DATA_W-1:0] d_q_q, d_q_d;
  logic              i_done_q, i_done_d;
  logic              d_done_q, d_done_d;

  logic pick_d_on_tie;
  logic grant_i;
  logic grant_d;

  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    pick_d_on_tie = (last_grant_q == LG_I);
`else
    pick_d_on_tie = 1'b1;
`endif
    grant_d = d_start & (~i_start | pick_d_on_tie);
    grant_i = i_start & ~grant_d;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    sdc_addr_d   = sdc_addr_q;
    sdc_data_d   = sdc_data_q;
    sdc_we_d     = sdc_we_q;
    sdc_start_d  = sdc_start_q;
    i_q_d        = i_q_q;
    d_q_d        = d_q_q;
    i_done_d     = 1'b0;
    d_done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          sdc_addr_d  = d_addr;
          sdc_data_d  = d_data;
          sdc_we_d    = d_we;
          sdc_start_d = 1'b1;
          state_d     = BUSY_D;
        end else if (grant_i) begin
          sdc_addr_d  = i_addr;
          sdc_data_d  = i_data;
          sdc_we_d    = i_we;
          sdc_start_d = 1'b1;
          state_d     = BUSY_I;
        end
      end
      BUSY_I: begin
        if (sdc_done) begin
          i_q_d        = sdc_q;
          i_done_d     = 1'b1;
          sdc_addr_d   = '0;
          sdc_data_d   = '0;
          sdc_we_d     = 1'b0;
          sdc_start_d  = 1'b0;
          last_grant_d = LG_I;
          state_d      = GAP;
        end
      end
      BUSY_D: begin
        if (sdc_done) begin
          d_q_d        = sdc_q;
          d_done_d     = 1'b1;
          sdc_addr_d   = '0;
          sdc_data_d   = '0;
          sdc_we_d     = 1'b0;
          sdc_start_d  = 1'b0;
          last_grant_d = LG_D;
          state_d      = GAP;
        end
      end
      // Turnaround: a start still held by the just-finished requester is not re-granted.
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= LG_I;
      sdc_addr_q   <= '0;
      sdc_data_q   <= '0;
      sdc_we_q     <= 1'b0;
      sdc_start_q  <= 1'b0;
      i_q_q        <= '0;
      d_q_q        <= '0;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      sdc_addr_q   <= sdc_addr_d;
      sdc_data_q   <= sdc_data_d;
      sdc_we_q     <= sdc_we_d;
      sdc_start_q  <= sdc_start_d;
      i_q_q        <= i_q_d;
      d_q_q        <= d_q_d;
      i_done_q     <= i_done_d;
      d_done_q     <= d_done_d;
    end
  end

  assign sdc_addr  = sdc_addr_q;
  assign sdc_data  = sdc_data_q;
  assign sdc_we    = sdc_we_q;
  assign sdc_start = sdc_start_q;
  assign i_q       = i_q_q;
  assign d_q       = d_q_q;
  assign i_done    = i_done_q;
  assign d_done    = d_done_q;

endmodule
